// File: rtl/debouncer_pkg.sv
// Shared types for the multi-channel debouncer.
// The channel mode chooses how a change is handled. EARLY acts on the change at once and then
// locks out. LATE acts only after the input has been stable.
package debouncer_pkg;

    typedef enum logic {
        EARLY = 1'b0,
        LATE  = 1'b1
    } debouncer_mode_t;

    localparam int STATE_W = 2;

    // The two transitional states share an encoding across modes:
    //   ST_TO_HIGH is WAIT_HIGH in LATE mode and HOLD_HIGH in EARLY mode.
    //   ST_TO_LOW  is WAIT_LOW  in LATE mode and HOLD_LOW  in EARLY mode.
    typedef enum logic [STATE_W-1:0] {
        ST_LOW     = 2'd0,
        ST_TO_HIGH = 2'd1,
        ST_HIGH    = 2'd2,
        ST_TO_LOW  = 2'd3
    } debouncer_state_t;

endpackage

// File: rtl/debouncer_channel.sv
// One debounce channel: a 4-state FSM, a tick counter, and registered level/edge outputs.
// The 'state' port exposes the FSM state for debug.
module debouncer_channel
    import debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  debouncer_mode_t  mode,
    input  logic             tick,
    input  logic             sample,
    output logic             o_out,
    output logic             o_rise,
    output logic             o_fall,
    output debouncer_state_t state
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    debouncer_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, fall_q;
    logic             last_tick;

    // In LATE mode a reverting input in a WAIT state beats a coinciding tick.
    // In EARLY mode the input is ignored in HOLD states.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_tick = (cnt_q == CW'(STABLE_TICKS - 1));
        case (state_q)
            ST_LOW: begin
                if (sample) begin
                    state_d = ST_TO_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_TO_HIGH: begin
                if (mode == LATE && !sample) begin
                    state_d = ST_LOW;
                end else if (tick) begin
                    if (last_tick) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (!sample) begin
                    state_d = ST_TO_LOW;
                    cnt_d   = '0;
                end
            end
            ST_TO_LOW: begin
                if (mode == LATE && sample) begin
                    state_d = ST_HIGH;
                end else if (tick) begin
                    if (last_tick) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
        if (mode == LATE) begin
            out_d = (state_d == ST_HIGH) || (state_d == ST_TO_LOW);
        end else begin
            out_d = (state_d == ST_TO_HIGH) || (state_d == ST_HIGH);
        end
    end

    // State, counter and registered outputs.
    // The edge pulses appear in the same cycle as the new level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= out_d & ~out_q;
            fall_q  <= ~out_d & out_q;
        end
    end

    assign o_out  = out_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;
    assign state  = state_q;

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer top.
// It holds the shared debounce tick counter, the optional input synchronizer and N_CH channel
// instances.
// Define DEBOUNCER_SYNC_EN to put a 2-flop synchronizer on every input bit; this adds 2 cycles
// of latency.
// dbg_state carries each channel's FSM state, 2 bits per channel, with channel i at [2i+1:2i].
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int              N_CH         = 4,
    parameter int              TICK_DIV     = 1_250_000,
    parameter int              STABLE_TICKS = 2,
    parameter logic [N_CH-1:0] LATE_MASK    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           i_signal,
    output logic [N_CH-1:0]           o_out,
    output logic [N_CH-1:0]           o_rise,
    output logic [N_CH-1:0]           o_fall,
    output logic [STATE_W*N_CH-1:0]   dbg_state
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [N_CH-1:0] sample;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // Free-running tick counter, 0..TICK_DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

`ifdef DEBOUNCER_SYNC_EN
    logic [N_CH-1:0] sync_q1, sync_q2;

    // Two-flop synchronizer for asynchronous pin inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= i_signal;
            sync_q2 <= sync_q1;
        end
    end

    assign sample = sync_q2;
`else
    assign sample = i_signal;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam debouncer_mode_t MODE = LATE_MASK[i] ? LATE : EARLY;
        debouncer_state_t ch_state;

        debouncer_channel #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .mode   (MODE),
            .tick   (tick),
            .sample (sample[i]),
            .o_out  (o_out[i]),
            .o_rise (o_rise[i]),
            .o_fall (o_fall[i]),
            .state  (ch_state)
        );

        assign dbg_state[STATE_W*i +: STATE_W] = ch_state;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi with N_CH=2, TICK_DIV=4, STABLE_TICKS=3, LATE_MASK=2'b10.
// Each driven cycle steps a reference model and queues the expected {out, rise, fall}.
// A monitor pops one entry after every clock edge and compares it.
module tb_debouncer_multi;

    localparam int          N_CH  = 2;
    localparam int          TD    = 4;
    localparam int          ST    = 3;
    localparam logic [1:0]  LMASK = 2'b10;

    logic        clk;
    logic        rst;
    logic [1:0]  i_signal;
    logic [1:0]  o_out, o_rise, o_fall;
    logic [3:0]  dbg_state;

    int n_cmp;
    int n_err;

    logic [5:0] exp_q[$];
    logic [5:0] mon_exp, mon_got;

    // Reference model state.
    // m_anchor is the cycle that started the current LATE run or EARLY lockout; -1 means none.
    logic [1:0] m_out;
    int         m_anchor[2];
    int         m_k;

    debouncer_multi #(
        .N_CH         (N_CH),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .LATE_MASK    (LMASK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_signal  (i_signal),
        .o_out     (o_out),
        .o_rise    (o_rise),
        .o_fall    (o_fall),
        .dbg_state (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of tick cycles in the window (a, b].
    // Ticks fall in cycles k with k % TD == TD-1, where cycle 0 is the first cycle after reset.
    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TD - (a + 1) / TD;
    endfunction

    function automatic void model_reset();
        m_out       = 2'b00;
        m_anchor[0] = -1;
        m_anchor[1] = -1;
        m_k         = 0;
    endfunction

    // Advance the model by one cycle with input s. Return the expected outputs after the edge.
    function automatic logic [5:0] model_step(input logic [1:0] s);
        logic [1:0] old;
        logic       locked;
        old = m_out;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (LMASK[ch]) begin
                if (s[ch] == m_out[ch]) begin
                    m_anchor[ch] = -1;
                end else if (m_anchor[ch] < 0) begin
                    m_anchor[ch] = m_k;
                end else if (ticks_in(m_anchor[ch], m_k) >= ST) begin
                    m_out[ch]    = s[ch];
                    m_anchor[ch] = -1;
                end
            end else begin
                locked = (m_anchor[ch] >= 0) && (ticks_in(m_anchor[ch], m_k - 1) < ST);
                if (!locked) begin
                    m_anchor[ch] = -1;
                    if (s[ch] != m_out[ch]) begin
                        m_out[ch]    = s[ch];
                        m_anchor[ch] = m_k;
                    end
                end
            end
        end
        m_k++;
        return {m_out, m_out & ~old, ~m_out & old};
    endfunction

    // Driver. It is called at a negedge, drives one cycle of input and returns at the next negedge.
    task automatic drive_cycle(input logic [1:0] s);
        i_signal = s;
        exp_q.push_back(model_step(s));
        @(negedge clk);
    endtask

    task automatic drive_n(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) drive_cycle(s);
    endtask

    task automatic check_now(input string name, input logic [1:0] got);
        n_cmp++;
        if (got !== 2'b00) begin
            n_err++;
            $display("FAIL %s got=%b required=00 t=%0t", name, got, $time);
        end
    endtask

    // Assert reset asynchronously in mid-cycle and check that the outputs clear at once.
    // Release it at a negedge; the next drive_cycle is then cycle 0.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_now("reset_out", o_out);
        check_now("reset_rise", o_rise);
        check_now("reset_fall", o_fall);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {o_out, o_rise, o_fall};
            n_cmp++;
            if (mon_got !== mon_exp) begin
                n_err++;
                $display("FAIL out_rise_fall t=%0t got=%b required=%b", $time, mon_got, mon_exp);
            end
        end
    end

    logic [1:0] rs;
    int         len, lvl;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        i_signal = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle.
        drive_n(2'b00, 6);
        // Clean step to 1 on channel 1 (LATE), then back to 0.
        drive_n(2'b10, 16);
        drive_n(2'b00, 16);
        // A 5-cycle glitch on channel 1 must not pass.
        drive_n(2'b10, 5);
        drive_n(2'b00, 12);
        // Channel 0 (EARLY) bounces 1,0,1,0,1 and then holds.
        drive_cycle(2'b01); drive_cycle(2'b00); drive_cycle(2'b01);
        drive_cycle(2'b00); drive_cycle(2'b01);
        drive_n(2'b01, 16);
        drive_n(2'b00, 20);
        // Channel 0 drops during HOLD_HIGH and stays low.
        drive_n(2'b01, 2);
        drive_n(2'b00, 20);
        // Both channels step together, and channel 1 reverts in a tick cycle.
        drive_cycle(2'b11);
        while ((m_k % TD) != TD - 1) drive_cycle(2'b11);
        drive_cycle(2'b01);
        drive_n(2'b01, 16);
        drive_n(2'b00, 20);
        // Async reset with inputs high, then both channels rise afresh.
        drive_n(2'b11, 3);
        apply_reset();
        drive_n(2'b11, 20);
        drive_n(2'b00, 20);

        // Randomized bursts with varying bounce density, and one reset partway through.
        rs = 2'b00;
        for (int b = 0; b < 60; b++) begin
            len = $urandom_range(4, 40);
            lvl = $urandom_range(0, 3);
            for (int c = 0; c < len; c++) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    if ($urandom_range(0, 7) < lvl) rs[ch] = ~rs[ch];
                end
                drive_cycle(rs);
            end
            if (b == 30) apply_reset();
        end
        drive_n(2'b00, 20);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d entries left required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
# debouncer_multi

Parametrised multi-channel debouncer. It conditions N_CH raw inputs from push-buttons or switches against one shared debounce tick. Each channel is independently configured as EARLY (react immediately, then lock out) or LATE (react only after the input is stable). The block also produces one-cycle rise and fall pulses per channel, and sits between the board pins and the FSM/control logic of the top level.

## Interface
- N_CH, 4: number of independent channels (≥1).
- TICK_DIV, 1_250_000: clk cycles per debounce tick (≥2); 10 ms at 125 MHz.
- STABLE_TICKS, 2: ticks of stability (LATE) or lockout (EARLY) (≥1).
- LATE_MASK, '0: N_CH-bit mask. Bit i = 1 makes channel i LATE; bit i = 0 makes it EARLY.
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- i_signal, input, N_CH: raw inputs.
- o_out, output, N_CH: debounced levels.
- o_rise, output, N_CH: one-cycle pulse on each debounced 0→1 transition.
- o_fall, output, N_CH: one-cycle pulse on each debounced 1→0 transition.

## Operation
- Tick counter runs 0..TICK_DIV-1 and wraps. The internal tick is high for exactly the one cycle in which the counter equals TICK_DIV-1. The tick is shared by all channels.
- Sample s[i] is i_signal[i], or its synchronized copy when the synchronizer is compiled in (see Configuration).
- Each channel has a 4-state FSM (LOW, WAIT_HIGH/HOLD_HIGH, HIGH, WAIT_LOW/HOLD_LOW) and a tick counter of width $clog2(STABLE_TICKS+1).
- LATE channel:
  - LOW: s=1 → WAIT_HIGH, counter cleared.
  - WAIT_HIGH: s=0 → LOW. Otherwise each tick increments the counter. A tick that brings the count to STABLE_TICKS → HIGH.
  - HIGH and WAIT_LOW: symmetric, with s=0 / s=1 roles swapped.
  - o_out = 1 only in HIGH and WAIT_LOW.
- EARLY channel:
  - LOW: s=1 → HOLD_HIGH, with o_out=1 in the same transition; counter cleared.
  - HOLD_HIGH: s is ignored. After STABLE_TICKS ticks → HIGH.
  - HIGH: s=0 → HOLD_LOW with o_out=0.
  - HOLD_LOW: after STABLE_TICKS ticks → LOW.
  - o_out = 1 in HOLD_HIGH and HIGH.
- o_rise[i] and o_fall[i] are registered. Each is high for exactly one cycle: the first cycle in which the new o_out[i] value is visible.
- Simultaneous tick and input change in a WAIT state: the input change wins. The FSM returns to the stable state and the tick is not counted.
- Channels never interact. Any combination of simultaneous events across channels is legal.

## Timing
- Reset (rst=0, asynchronous): o_out, o_rise and o_fall are 0; all FSMs go to LOW; all counters go to 0, including the tick counter.
- After reset release, the first tick occurs in cycle TICK_DIV.
- EARLY latency: o_out changes 1 clk after the s change.
- LATE latency: o_out changes 1 clk after the STABLE_TICKS-th tick following entry to WAIT. The resulting stable time is between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles.
- Reset asserted mid-WAIT or mid-HOLD: the operation is abandoned immediately. No pulse is emitted and no pending output change occurs after release.
- A pulse on o_rise or o_fall never lasts more than one cycle, even when TICK_DIV=2.

## Configuration
- DEBOUNCER_SYNC_EN defined: a 2-flop synchronizer is placed on each i_signal bit, and every latency above grows by 2 cycles.
- DEBOUNCER_SYNC_EN undefined: i_signal feeds the FSMs directly. This requires inputs that are already synchronous to clk.

## Structure
- debouncer_pkg holds:
  - the enum debouncer_mode_t (EARLY, LATE);
  - the channel-state enum debouncer_state_t.
- Sub-module debouncer_channel contains one FSM, its counter and its edge-pulse registers. It takes mode, tick and sample as inputs.
- The top level contains the tick counter, the optional synchronizer, and a generate loop of N_CH debouncer_channel instances.

## Test plan
All scenarios use N_CH=2, TICK_DIV=4, STABLE_TICKS=3, LATE_MASK=2'b10, with the synchronizer off.
- Async reset pulsed mid-cycle with inputs at 1 → all outputs 0 immediately. After release, the first tick is at cycle 4 and both channels pass through the 0→1 sequence afresh.
- Channel 1 (LATE) clean step 0→1 → o_out[1] rises 9–13 cycles later, with o_rise[1] high for exactly 1 cycle in that same cycle.
- Channel 1 high glitch of 5 cycles → o_out[1] stays 0, and o_rise and o_fall stay 0.
- Channel 0 (EARLY) bounce 1,0,1,0,1 at 1-cycle spacing → o_out[0]=1 one cycle after the first 1 and stays 1, with a single o_rise[0] pulse.
- Channel 0 drops to 0 during HOLD_HIGH and stays 0 → o_out[0] falls 1 cycle after the hold ends, with a single o_fall[0] pulse.
- Both channels step simultaneously while a tick coincides with a channel 1 glitch back to 0 → channel 1 returns to LOW with no change to o_out[1], while channel 0 behaves as if alone.
